// File: rtl/serial_subtractor.sv
// Chunked multi-cycle subtractor: d = a - b - bi, CHUNK bits per clock.
// Define SERIAL_SUBTRACTOR_FLAGS_EN to add registered zf/nf result flags.
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bi,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo,
   output logic             ov
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   ,
   output logic             zf,
   output logic             nf
`endif
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic             bo_q, bo_d, ov_q, ov_d;
   logic             zf_q, zf_d, nf_q, nf_d;
   logic [CHUNK-1:0] a_k, b_k;
   logic [CHUNK:0]   sub;
   logic             last, accept;

   assign last   = (cnt_q == CW'(N - 1));
   assign accept = start & (state_q != RUN);

   // Extra top bit of the widened difference is the chunk borrow-out
   assign a_k = a_q[cnt_q*CHUNK +: CHUNK];
   assign b_k = b_q[cnt_q*CHUNK +: CHUNK];
   assign sub = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK{1'b0}}, brw_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last)  state_d = DONE;
         DONE:    state_d = start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      unique case (state_q)
         IDLE:    ready = 1'b1;
         RUN:     busy  = 1'b1;
         DONE: begin
            ready = 1'b1;
            done  = 1'b1;
         end
         default: ready = 1'b0;
      endcase
   end

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      d_d   = d_q;
      cnt_d = cnt_q;
      brw_d = brw_q;
      bo_d  = bo_q;
      ov_d  = ov_q;
      zf_d  = zf_q;
      nf_d  = nf_q;
      if (accept) begin
         a_d   = a;
         b_d   = b;
         brw_d = bi;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         d_d[cnt_q*CHUNK +: CHUNK] = sub[CHUNK-1:0];
         brw_d = sub[CHUNK];
         cnt_d = last ? '0 : cnt_q + CW'(1);
         if (last) begin
            bo_d = sub[CHUNK];
            ov_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &
                   (d_d[WIDTH-1] != a_q[WIDTH-1]);
            zf_d = (d_d == '0);
            nf_d = d_d[WIDTH-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         d_q   <= '0;
         cnt_q <= '0;
         brw_q <= 1'b0;
         bo_q  <= 1'b0;
         ov_q  <= 1'b0;
         zf_q  <= 1'b0;
         nf_q  <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         d_q   <= d_d;
         cnt_q <= cnt_d;
         brw_q <= brw_d;
         bo_q  <= bo_d;
         ov_q  <= ov_d;
         zf_q  <= zf_d;
         nf_q  <= nf_d;
      end
   end

   assign d  = d_q;
   assign bo = bo_q;
   assign ov = ov_q;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   assign zf = zf_q;
   assign nf = nf_q;
`else
   logic unused_flags;
   assign unused_flags = zf_q ^ nf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: random and directed operations
// checked against an arithmetic reference model.
module tb_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        bi = 1'b0;
   logic        ready, busy, done, bo, ov;
   logic [31:0] d;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
   logic        zf, nf;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] d;
      logic        bo;
      logic        ov;
      logic        zf;
      logic        nf;
      int          sc;
   } exp_t;

   exp_t q[$];

   serial_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a), .b(b), .bi(bi),
      .ready(ready), .busy(busy), .done(done),
      .d(d), .bo(bo), .ov(ov)
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      , .zf(zf), .nf(nf)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] ia, ib,
                                  input logic ibi, input int sc);
      exp_t e;
      longint ua, ub, sa, sb, r, s;
      ua = longint'(ia);
      ub = longint'(ib);
      r  = ua - ub - longint'(ibi);
      sa = longint'($signed(ia));
      sb = longint'($signed(ib));
      s  = sa - sb - longint'(ibi);
      e.d  = r[31:0];
      e.bo = (r < 0);
      e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      e.zf = (e.d == 32'd0);
      e.nf = e.d[31];
      e.sc = sc;
      return e;
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = q.pop_front();
               chk("latency", 64'(cyc - e.sc), 5);
               chk("d", d, e.d);
               chk("bo", bo, e.bo);
               chk("ov", ov, e.ov);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
               chk("zf", zf, e.zf);
               chk("nf", nf, e.nf);
`endif
            end
         end
      end
   end

   // Entered at a negedge; returns at the negedge starting start's drop
   task automatic issue(input logic [31:0] ia, ib, input logic ibi,
                        input int hold);
      int t = 0;
      while (!ready && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("ready_wait", ready, 1);
      a = ia;
      b = ib;
      bi = ibi;
      start = 1'b1;
      q.push_back(model(ia, ib, ibi, cyc));
      @(negedge clk);
      chk("busy_run", {busy, ready}, 2'b10);
      for (int i = 0; i < hold; i++) begin
         a = $urandom;
         b = $urandom;
         bi = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      bi = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((q.size() != 0 || busy) && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 64'(q.size()), 0);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_flags", {ready, busy, done, bo, ov}, 5'b10000);
      chk("rst_d", d, 0);
      rst_n = 1'b1;
      @(negedge clk);

      issue(32'h5, 32'h3, 1'b0, 0);
      wait_idle();
      issue(32'h0, 32'h1, 1'b0, 0);
      wait_idle();
      issue(32'h80000000, 32'h1, 1'b0, 0);
      wait_idle();
      issue(32'h100, 32'h1, 1'b1, 0);
      wait_idle();
      issue(32'h12345678, 32'h12345678, 1'b0, 0);
      wait_idle();

      issue(32'h1000, 32'h0FFF, 1'b0, 3);
      wait_idle();

      issue(32'hDEADBEEF, 32'h01234567, 1'b1, 0);
      issue(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
      wait_idle();

      issue(32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_flags", {ready, busy, done, bo, ov}, 5'b10000);
      chk("midrst_d", d, 0);
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      issue(32'h00010000, 32'h1, 1'b0, 0);
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         issue($urandom, $urandom, 1'($urandom_range(0, 1)), 0);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle chunked subtractor computing d = a - b - bi over WIDTH bits, CHUNK bits per clock.
- The borrow is held in a register between chunks.
- Used in datapaths where a full-width combinational ripple subtract cannot meet timing; complements the combinational full-adder chain.
- Start/done handshake; operands captured at start; results held until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width; must be a positive multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  minuend; sampled on accepted start.
- b  input  WIDTH  subtrahend; sampled on accepted start.
- bi  input  1  borrow-in; sampled on accepted start.
- ready  output  1  high when a start can be accepted (state IDLE or DONE).
- busy  output  1  high in state RUN.
- done  output  1  one-cycle pulse; d/bo/ov valid from this cycle.
- d  output  WIDTH  difference a - b - bi modulo 2^WIDTH.
- bo  output  1  borrow-out; 1 iff unsigned a < b + bi.
- ov  output  1  two's-complement overflow of the signed subtract.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; ready=1, busy=0, done=0; d=0, bo=0, ov=0; internal operand regs, borrow reg and chunk counter cleared.
- FSM states:
  - IDLE: ready=1. start=1 -> RUN; capture a, b; borrow reg <= bi; counter <= 0.
  - RUN: busy=1, ready=0. Each cycle processes chunk k = counter, i.e. bits [k*CHUNK +: CHUNK].
    - d chunk k = a_k - b_k - borrow.
    - borrow <= chunk borrow-out.
    - counter <= counter+1.
    - On the last chunk (counter = N-1): next state DONE; bo <= final borrow; ov <= (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), computed from captured operands and the final d.
  - DONE: done=1, ready=1 for exactly one cycle. start=1 -> RUN (back-to-back, same capture as IDLE); otherwise -> IDLE.
- Latency: start accepted at edge E. Chunks are processed in the N cycles after E. done=1 in the cycle after the Nth RUN cycle, i.e. N+1 cycles after the start cycle. N=4 by default.
- Throughput: one operation per N+1 cycles.
- Results d/bo/ov hold from done until the next accepted start. During RUN, d is updated chunk-wise (partial values visible); consumers use d only when done/ready.
- start while busy=1: ignored; no capture, no effect on the in-flight operation. a/b/bi changes during RUN: no effect.
- Wrap-around: d is modulo 2^WIDTH. 0 - 1 gives all-ones with bo=1.
- Reset asserted mid-RUN: the operation is aborted immediately; all outputs go to reset values; no done is generated.
- N=1 (CHUNK=WIDTH): a single RUN cycle, then DONE; behaviour is otherwise identical.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_FLAGS_EN.
- When defined: extra outputs zf (1: d == 0) and nf (1: d[WIDTH-1]). Both are registered and updated in the same cycle as bo/ov, valid with done, and reset to 0.
- When undefined: the ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- WIDTH=32, CHUNK=8; a=0x00000005, b=0x00000003, bi=0, start pulse -> done exactly 5 cycles after the start cycle; d=0x00000002, bo=0, ov=0.
- a=0x00000000, b=0x00000001, bi=0 -> d=0xFFFFFFFF, bo=1, ov=0; with FLAGS_EN: zf=0, nf=1.
- a=0x80000000, b=0x00000001, bi=0 -> d=0x7FFFFFFF, bo=0, ov=1.
- Cross-chunk borrow: a=0x00000100, b=0x00000001, bi=1 -> d=0x000000FE, bo=0. Also a=0x12345678, b=0x12345678, bi=0 -> d=0, bo=0; with FLAGS_EN: zf=1.
- Busy handling: start held high through RUN with changing a/b -> only the first operation completes with its captured result. A start in the DONE cycle is accepted, and the second done follows 5 cycles later.
- Reset: rst_n pulsed low during the 2nd RUN cycle -> outputs are 0 immediately; ready=1, busy=0; no done pulse afterwards; the next start operates normally.
